// File: rtl/in_service_ctrl.sv
// In-service register for a rotating-priority interrupt controller.
// Tracks acknowledged levels, resolves the highest eligible one, and handles EOI, AEOI and rotation.
module in_service_ctrl #(
   parameter int NUM_LEVELS = 8,
   parameter int LVL_W      = $clog2(NUM_LEVELS)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  latch_in_service,
   input  logic [NUM_LEVELS-1:0] interrupt,
   input  logic                  eoi_nonspecific,
   input  logic                  eoi_specific,
   input  logic [LVL_W-1:0]      eoi_level,
   input  logic                  rotate_on_eoi,
   input  logic                  auto_eoi,
   input  logic                  auto_rotate,
   input  logic                  set_priority,
   input  logic [LVL_W-1:0]      priority_level,
   input  logic                  special_mask_mode,
   input  logic [NUM_LEVELS-1:0] interrupt_mask,
   output logic [NUM_LEVELS-1:0] in_service_register,
   output logic [NUM_LEVELS-1:0] highest_level_in_service,
   output logic [LVL_W-1:0]      isr_level,
   output logic                  isr_valid,
   output logic [LVL_W-1:0]      priority_rotate,
   output logic                  eoi_error
);

   typedef enum logic {IDLE, AEOI_CLR} state_t;

   state_t                  state_q, state_d;
   logic [NUM_LEVELS-1:0]   isr_q, isr_d;
   logic [LVL_W-1:0]        prio_q, prio_d;
   logic [LVL_W-1:0]        aeoi_lvl_q, aeoi_lvl_d;
   logic                    eoi_error_q, eoi_error_d;

   logic [NUM_LEVELS-1:0]   eligible;
   logic [NUM_LEVELS-1:0]   highest;
   logic [NUM_LEVELS-1:0]   latch_bit;
   logic [LVL_W-1:0]        latch_lvl;
   logic [NUM_LEVELS-1:0]   clear_vec;
   logic                    eoi_done;
   logic [LVL_W-1:0]        eoi_lvl;

   // Scan from lowest to highest priority so the highest-priority set bit is the last one kept.
   function automatic logic [NUM_LEVELS-1:0] pick_highest(
      input logic [NUM_LEVELS-1:0] vec,
      input logic [LVL_W-1:0]      lowest
   );
      logic [NUM_LEVELS-1:0] res;
      logic [LVL_W-1:0]      idx;
      res = '0;
      for (int k = NUM_LEVELS - 1; k >= 0; k--) begin
         idx = lowest + LVL_W'(k + 1);
         if (vec[idx]) begin
            res      = '0;
            res[idx] = 1'b1;
         end
      end
      return res;
   endfunction

   function automatic logic [LVL_W-1:0] onehot_idx(input logic [NUM_LEVELS-1:0] vec);
      logic [LVL_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_LEVELS; i++) begin
         if (vec[i]) idx = idx | LVL_W'(i);
      end
      return idx;
   endfunction

   assign eligible = special_mask_mode ? (isr_q & ~interrupt_mask) : isr_q;
   assign highest  = pick_highest(eligible, prio_q);

   assign highest_level_in_service = highest;
   assign isr_level                = onehot_idx(highest);
   assign isr_valid                = |highest;
   assign in_service_register      = isr_q;
   assign priority_rotate          = prio_q;
   assign eoi_error                = eoi_error_q;

   always_comb begin
      state_d     = IDLE;
      aeoi_lvl_d  = aeoi_lvl_q;
      clear_vec   = '0;
      eoi_done    = 1'b0;
      eoi_lvl     = '0;
      latch_bit   = latch_in_service ? pick_highest(interrupt, prio_q) : '0;
      latch_lvl   = onehot_idx(latch_bit);
      eoi_error_d = eoi_nonspecific & ~eoi_specific & ~isr_valid;

      if (eoi_specific) begin
         clear_vec[eoi_level] = 1'b1;
         eoi_done             = 1'b1;
         eoi_lvl              = eoi_level;
      end else if (eoi_nonspecific && isr_valid) begin
         clear_vec = highest;
         eoi_done  = 1'b1;
         eoi_lvl   = isr_level;
      end

      if (state_q == AEOI_CLR) clear_vec[aeoi_lvl_q] = 1'b1;

      // Clears act on the pre-edge ISR; new latches are ORed in afterwards.
      isr_d = (isr_q & ~clear_vec) | latch_bit;

      if (set_priority)                         prio_d = priority_level;
      else if (rotate_on_eoi && eoi_done)       prio_d = eoi_lvl;
      else if (state_q == AEOI_CLR && auto_rotate) prio_d = aeoi_lvl_q;
      else                                      prio_d = prio_q;

      if (auto_eoi && (|latch_bit)) begin
         state_d    = AEOI_CLR;
         aeoi_lvl_d = latch_lvl;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         isr_q       <= '0;
         prio_q      <= LVL_W'(NUM_LEVELS - 1);
         aeoi_lvl_q  <= '0;
         eoi_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         isr_q       <= isr_d;
         prio_q      <= prio_d;
         aeoi_lvl_q  <= aeoi_lvl_d;
         eoi_error_q <= eoi_error_d;
      end
   end

endmodule

// File: tb/tb_in_service_ctrl.sv
// Bench for in_service_ctrl: a level-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_in_service_ctrl;
   localparam int N = 8;
   localparam int W = 3;

   logic         clock = 1'b0;
   logic         reset;
   logic         latch_in_service;
   logic [N-1:0] interrupt;
   logic         eoi_nonspecific;
   logic         eoi_specific;
   logic [W-1:0] eoi_level;
   logic         rotate_on_eoi;
   logic         auto_eoi;
   logic         auto_rotate;
   logic         set_priority;
   logic [W-1:0] priority_level;
   logic         special_mask_mode;
   logic [N-1:0] interrupt_mask;
   logic [N-1:0] in_service_register;
   logic [N-1:0] highest_level_in_service;
   logic [W-1:0] isr_level;
   logic         isr_valid;
   logic [W-1:0] priority_rotate;
   logic         eoi_error;

   int vectors    = 0;
   int miscompares = 0;
   bit check_en   = 1'b0;

   in_service_ctrl #(.NUM_LEVELS(N), .LVL_W(W)) dut (
      .clock                    (clock),
      .reset                    (reset),
      .latch_in_service         (latch_in_service),
      .interrupt                (interrupt),
      .eoi_nonspecific          (eoi_nonspecific),
      .eoi_specific             (eoi_specific),
      .eoi_level                (eoi_level),
      .rotate_on_eoi            (rotate_on_eoi),
      .auto_eoi                 (auto_eoi),
      .auto_rotate              (auto_rotate),
      .set_priority             (set_priority),
      .priority_level           (priority_level),
      .special_mask_mode        (special_mask_mode),
      .interrupt_mask           (interrupt_mask),
      .in_service_register      (in_service_register),
      .highest_level_in_service (highest_level_in_service),
      .isr_level                (isr_level),
      .isr_valid                (isr_valid),
      .priority_rotate          (priority_rotate),
      .eoi_error                (eoi_error)
   );

   always #5 clock = ~clock;

   // Reference model state: ISR bits, lowest-priority level, pending auto-clear level (-1 = none).
   logic [N-1:0] m_isr  = '0;
   int           m_rot  = N - 1;
   int           m_pend = -1;
   logic         m_err  = 1'b0;

   // Highest-priority set level: walk levels from rot+1 downwards in priority.
   function automatic int m_top(input logic [N-1:0] v, input int rot);
      for (int p = 0; p < N; p++) begin
         int l;
         l = (rot + 1 + p) % N;
         if (v[l]) return l;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   logic [N-1:0] mu_elig, mu_clr, mu_set;
   int           mu_h, mu_li, mu_eoi, mu_rot, mu_pend;

   always @(posedge clock) begin
      if (reset) begin
         m_isr  <= '0;
         m_rot  <= N - 1;
         m_pend <= -1;
         m_err  <= 1'b0;
      end else begin
         mu_elig = special_mask_mode ? (m_isr & ~interrupt_mask) : m_isr;
         mu_h    = m_top(mu_elig, m_rot);
         mu_clr  = '0;
         mu_set  = '0;
         mu_eoi  = -1;
         if (eoi_specific) mu_eoi = int'(eoi_level);
         else if (eoi_nonspecific) mu_eoi = mu_h;
         if (mu_eoi >= 0) mu_clr[mu_eoi] = 1'b1;
         if (m_pend >= 0) mu_clr[m_pend] = 1'b1;
         mu_li = latch_in_service ? m_top(interrupt, m_rot) : -1;
         if (mu_li >= 0) mu_set[mu_li] = 1'b1;
         mu_pend = (auto_eoi && mu_li >= 0) ? mu_li : -1;
         if (set_priority) mu_rot = int'(priority_level);
         else if (rotate_on_eoi && mu_eoi >= 0) mu_rot = mu_eoi;
         else if (auto_rotate && m_pend >= 0) mu_rot = m_pend;
         else mu_rot = m_rot;
         m_isr  <= (m_isr & ~mu_clr) | mu_set;
         m_rot  <= mu_rot;
         m_pend <= mu_pend;
         m_err  <= eoi_nonspecific && !eoi_specific && mu_h < 0;
      end
   end

   logic [N-1:0] mc_elig;
   int           mc_h;

   always @(negedge clock) begin
      if (check_en) begin
         mc_elig = special_mask_mode ? (m_isr & ~interrupt_mask) : m_isr;
         mc_h    = m_top(mc_elig, m_rot);
         chk("model_isr",       int'(in_service_register), int'(m_isr));
         chk("model_highest",   int'(highest_level_in_service), (mc_h < 0) ? 0 : (1 << mc_h));
         chk("model_isr_level", int'(isr_level), (mc_h < 0) ? 0 : mc_h);
         chk("model_isr_valid", int'(isr_valid), (mc_h >= 0) ? 1 : 0);
         chk("model_prio",      int'(priority_rotate), m_rot);
         chk("model_eoi_error", int'(eoi_error), int'(m_err));
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulses_off();
      latch_in_service = 1'b0;
      interrupt        = '0;
      eoi_nonspecific  = 1'b0;
      eoi_specific     = 1'b0;
      set_priority     = 1'b0;
   endtask

   task automatic latch(input logic [N-1:0] v);
      latch_in_service = 1'b1;
      interrupt        = v;
      tick();
      pulses_off();
   endtask

   task automatic spec_eoi(input int lvl);
      eoi_specific = 1'b1;
      eoi_level    = W'(lvl);
      tick();
      pulses_off();
   endtask

   task automatic nonspec_eoi();
      eoi_nonspecific = 1'b1;
      tick();
      pulses_off();
   endtask

   task automatic set_prio(input int lvl);
      set_priority   = 1'b1;
      priority_level = W'(lvl);
      tick();
      pulses_off();
   endtask

   initial begin
      reset             = 1'b1;
      pulses_off();
      eoi_level         = '0;
      rotate_on_eoi     = 1'b0;
      auto_eoi          = 1'b0;
      auto_rotate       = 1'b0;
      priority_level    = '0;
      special_mask_mode = 1'b0;
      interrupt_mask    = '0;
      tick();
      check_en = 1'b1;
      tick();
      reset = 1'b0;
      chk("reset_isr",   int'(in_service_register), 'h00);
      chk("reset_prio",  int'(priority_rotate), 7);
      chk("reset_valid", int'(isr_valid), 0);
      chk("reset_err",   int'(eoi_error), 0);

      // Fully nested
      latch(8'h04);
      latch(8'h01);
      chk("nested_isr",     int'(in_service_register), 'h05);
      chk("nested_highest", int'(highest_level_in_service), 'h01);
      chk("nested_level",   int'(isr_level), 0);
      nonspec_eoi();
      chk("nested_eoi_isr",     int'(in_service_register), 'h04);
      chk("nested_eoi_highest", int'(highest_level_in_service), 'h04);
      spec_eoi(2);

      // Rotate on EOI
      latch(8'h08);
      rotate_on_eoi = 1'b1;
      nonspec_eoi();
      rotate_on_eoi = 1'b0;
      chk("rot_isr",  int'(in_service_register), 'h00);
      chk("rot_prio", int'(priority_rotate), 3);
      latch(8'h01);
      latch(8'h10);
      chk("rot_isr2",    int'(in_service_register), 'h11);
      chk("rot_highest", int'(highest_level_in_service), 'h10);
      set_prio(7);
      spec_eoi(0);
      spec_eoi(4);

      // Special mask mode
      latch(8'h02);
      latch(8'h04);
      special_mask_mode = 1'b1;
      interrupt_mask    = 8'h04;
      #1;
      chk("smm_highest", int'(highest_level_in_service), 'h02);
      nonspec_eoi();
      chk("smm_eoi_isr", int'(in_service_register), 'h04);
      special_mask_mode = 1'b0;
      #1;
      chk("smm_off_highest", int'(highest_level_in_service), 'h04);
      interrupt_mask = '0;
      spec_eoi(2);

      // Auto EOI with auto rotate
      auto_eoi    = 1'b1;
      auto_rotate = 1'b1;
      latch(8'h20);
      chk("aeoi_set",  int'(in_service_register), 'h20);
      tick();
      chk("aeoi_clr",  int'(in_service_register), 'h00);
      chk("aeoi_prio", int'(priority_rotate), 5);
      latch(8'h20);
      chk("aeoi_b2b_1", int'(in_service_register), 'h20);
      latch(8'h40);
      chk("aeoi_b2b_2", int'(in_service_register), 'h40);
      tick();
      chk("aeoi_b2b_clr",  int'(in_service_register), 'h00);
      chk("aeoi_b2b_prio", int'(priority_rotate), 6);
      auto_eoi    = 1'b0;
      auto_rotate = 1'b0;
      set_prio(7);

      // Set beats clear of the same bit
      latch(8'h02);
      latch_in_service = 1'b1;
      interrupt        = 8'h02;
      eoi_specific     = 1'b1;
      eoi_level        = 3'd1;
      tick();
      pulses_off();
      chk("set_wins_isr", int'(in_service_register), 'h02);
      spec_eoi(1);
      chk("spec_clear_isr", int'(in_service_register), 'h00);
      spec_eoi(1);
      chk("spec_clear_empty_err", int'(eoi_error), 0);

      // Non-specific EOI with nothing in service
      nonspec_eoi();
      chk("eoi_err_pulse", int'(eoi_error), 1);
      tick();
      chk("eoi_err_drop", int'(eoi_error), 0);

      // Specific EOI wins over a simultaneous non-specific one
      latch(8'h01);
      latch(8'h04);
      eoi_specific    = 1'b1;
      eoi_nonspecific = 1'b1;
      eoi_level       = 3'd2;
      tick();
      pulses_off();
      chk("both_eoi_isr", int'(in_service_register), 'h01);
      chk("both_eoi_err", int'(eoi_error), 0);
      spec_eoi(0);

      // Reset abandons a pending auto clear
      auto_eoi = 1'b1;
      latch(8'h08);
      chk("aeoi_pre_reset", int'(in_service_register), 'h08);
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      auto_eoi = 1'b0;
      chk("reset_aeoi_isr",  int'(in_service_register), 'h00);
      chk("reset_aeoi_prio", int'(priority_rotate), 7);
      latch(8'h08);
      tick();
      chk("post_reset_idle", int'(in_service_register), 'h08);
      spec_eoi(3);

      // Multi-bit acknowledge keeps only the highest-priority bit, including wrap
      latch(8'h90);
      chk("multi_latch", int'(in_service_register), 'h10);
      spec_eoi(4);
      set_prio(5);
      latch(8'h81);
      chk("multi_wrap",      int'(in_service_register), 'h80);
      chk("multi_wrap_prio", int'(priority_rotate), 5);
      tick();

      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
